// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the program counter, presents it to the
// instruction memory as a combinational read address and registers the
// returned word into the IF/ID pipeline register. Handles hazard stalls,
// branch/jump redirects, a single boot bubble after reset and keeps a
// running count of captured instructions for debug.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] Redirect_Target,
  input  logic [31:0] Instruction,
  output logic [31:0] Address,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PC,
  output logic        IF_ID_Valid,
  output logic        Misaligned_Redirect,
  output logic [31:0] Fetch_Count
);

  typedef enum logic [0:0] {
    StBoot,
    StRun
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  // Redirect targets are forced word-aligned; the dropped low bits only
  // feed the misalignment flag.
  logic [31:0] redirect_pc;
  logic        redirect_misaligned;

  assign redirect_pc         = {Redirect_Target[31:2], 2'b00};
  assign redirect_misaligned = (Redirect_Target[1:0] != 2'b00);

  // Next-state logic: Redirect beats Stall beats a normal fetch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_valid_d  = ifid_valid_q;
    misaligned_d  = 1'b0;
    fetch_count_d = fetch_count_q;

    unique case (state_q)
      StBoot: begin
        // Boot bubble: never capture, Stall ignored, Redirect still loads PC.
        state_d = StRun;
        if (Redirect) begin
          pc_d         = redirect_pc;
          ifid_instr_d = NOP_INSTR;
          ifid_pc_d    = 32'h0;
          ifid_valid_d = 1'b0;
          misaligned_d = redirect_misaligned;
        end
      end
      StRun: begin
        if (Redirect) begin
          pc_d         = redirect_pc;
          ifid_instr_d = NOP_INSTR;
          ifid_pc_d    = 32'h0;
          ifid_valid_d = 1'b0;
          misaligned_d = redirect_misaligned;
        end else if (Stall) begin
          // Hold everything; only the misalignment pulse is cleared.
        end else begin
          ifid_instr_d  = Instruction;
          ifid_pc_d     = pc_q;
          ifid_valid_d  = 1'b1;
          pc_d          = pc_q + 32'd4;
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  // State registers; asynchronous reset restores the boot bubble at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      ifid_instr_q  <= NOP_INSTR;
      ifid_pc_q     <= 32'h0;
      ifid_valid_q  <= 1'b0;
      misaligned_q  <= 1'b0;
      fetch_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_valid_q  <= ifid_valid_d;
      misaligned_q  <= misaligned_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Address comes straight from the PC register, so it never depends
  // combinationally on Stall or Redirect.
  assign Address             = pc_q;
  assign IF_ID_Instruction   = ifid_instr_q;
  assign IF_ID_PC            = ifid_pc_q;
  assign IF_ID_Valid         = ifid_valid_q;
  assign Misaligned_Redirect = misaligned_q;
  assign Fetch_Count         = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a small behavioural model predicts
// PC/count/flags, and each expected IF/ID capture is queued when its fetch
// cycle is driven and popped when the register should hold it.
module tb_fetch_stage;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        Stall;
  logic        Redirect;
  logic [31:0] Redirect_Target;
  logic [31:0] Instruction;
  logic [31:0] Address;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PC;
  logic        IF_ID_Valid;
  logic        Misaligned_Redirect;
  logic [31:0] Fetch_Count;

  int n_checks;
  int n_errors;

  // Model state
  logic [31:0] m_pc, m_cnt, m_ii, m_ipc;
  logic        m_iv, m_mis, m_boot;
  logic [63:0] sb[$];

  fetch_stage dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .Stall              (Stall),
    .Redirect           (Redirect),
    .Redirect_Target    (Redirect_Target),
    .Instruction        (Instruction),
    .Address            (Address),
    .IF_ID_Instruction  (IF_ID_Instruction),
    .IF_ID_PC           (IF_ID_PC),
    .IF_ID_Valid        (IF_ID_Valid),
    .Misaligned_Redirect(Misaligned_Redirect),
    .Fetch_Count        (Fetch_Count)
  );

  // Instruction memory: tags each word with its own address.
  assign Instruction = 32'hA000_0000 | Address;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = 32'h0;
    m_cnt  = 32'h0;
    m_ii   = Nop;
    m_ipc  = 32'h0;
    m_iv   = 1'b0;
    m_mis  = 1'b0;
    m_boot = 1'b1;
    sb.delete();
  endtask

  task automatic check_all(input string tag);
    check({tag, ".address"}, Address, m_pc);
    check({tag, ".instr"}, IF_ID_Instruction, m_ii);
    check({tag, ".ifid_pc"}, IF_ID_PC, m_ipc);
    check({tag, ".valid"}, 32'(IF_ID_Valid), 32'(m_iv));
    check({tag, ".misaligned"}, 32'(Misaligned_Redirect), 32'(m_mis));
    check({tag, ".count"}, Fetch_Count, m_cnt);
  endtask

  // Drive one cycle's inputs, predict, advance one edge and compare.
  task automatic cycle(input string tag, input logic st, input logic rd,
                       input logic [31:0] tgt);
    logic        cap;
    logic [63:0] e;
    cap             = 1'b0;
    Stall           = st;
    Redirect        = rd;
    Redirect_Target = tgt;
    if (m_boot) begin
      m_boot = 1'b0;
      m_mis  = 1'b0;
      if (rd) begin
        m_pc  = {tgt[31:2], 2'b00};
        m_mis = (tgt[1:0] != 2'b00);
      end
    end else if (rd) begin
      m_pc  = {tgt[31:2], 2'b00};
      m_ii  = Nop;
      m_ipc = 32'h0;
      m_iv  = 1'b0;
      m_mis = (tgt[1:0] != 2'b00);
    end else if (st) begin
      m_mis = 1'b0;
    end else begin
      sb.push_back({32'hA000_0000 | m_pc, m_pc});
      cap   = 1'b1;
      m_pc  = m_pc + 32'd4;
      m_cnt = m_cnt + 32'd1;
      m_iv  = 1'b1;
      m_mis = 1'b0;
    end
    @(posedge clk);
    #1;
    if (cap) begin
      if (sb.size() == 0) begin
        check({tag, ".scoreboard_empty"}, 32'd0, 32'd1);
      end else begin
        e     = sb.pop_front();
        m_ii  = e[63:32];
        m_ipc = e[31:0];
      end
    end
    check_all(tag);
    Stall    = 1'b0;
    Redirect = 1'b0;
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rst_n           = 1'b0;
    Stall           = 1'b0;
    Redirect        = 1'b0;
    Redirect_Target = 32'h0;
    model_reset();

    // Reset and boot bubble
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    check("reset.instr_const", IF_ID_Instruction, 32'h0000_0013);
    rst_n = 1'b1;
    cycle("boot", 1'b0, 1'b0, 32'h0);
    check("boot.valid_const", 32'(IF_ID_Valid), 32'd0);
    cycle("first", 1'b0, 1'b0, 32'h0);
    check("first.instr_const", IF_ID_Instruction, 32'hA000_0000);
    check("first.address_const", Address, 32'd4);
    check("first.count_const", Fetch_Count, 32'd1);

    // Sequential fetch
    for (int i = 0; i < 4; i++) cycle("seq", 1'b0, 1'b0, 32'h0);
    check("seq.ifid_pc_const", IF_ID_PC, 32'd16);
    check("seq.address_const", Address, 32'd20);
    check("seq.count_const", Fetch_Count, 32'd5);

    // Stall with PC=8 and a valid word in IF/ID
    cycle("to0", 1'b0, 1'b1, 32'h0);
    cycle("pre0", 1'b0, 1'b0, 32'h0);
    cycle("pre4", 1'b0, 1'b0, 32'h0);
    check("stall.start_pc", Address, 32'd8);
    cycle("stall1", 1'b1, 1'b0, 32'h0);
    cycle("stall2", 1'b1, 1'b0, 32'h0);
    check("stall.held_ifid", IF_ID_PC, 32'd4);
    cycle("unstall", 1'b0, 1'b0, 32'h0);
    check("unstall.instr_const", IF_ID_Instruction, 32'hA000_0008);
    check("unstall.address_const", Address, 32'd12);

    // Misaligned redirect overriding a simultaneous stall
    cycle("redir_stall", 1'b1, 1'b1, 32'h0000_0102);
    check("redir.address_const", Address, 32'h100);
    check("redir.misaligned_const", 32'(Misaligned_Redirect), 32'd1);
    cycle("after_redir", 1'b0, 1'b0, 32'h0);
    check("after_redir.instr_const", IF_ID_Instruction, 32'hA000_0100);
    check("after_redir.misaligned_const", 32'(Misaligned_Redirect), 32'd0);

    // Back-to-back misaligned redirects keep the pulse high
    cycle("mis_a", 1'b0, 1'b1, 32'h0000_0201);
    cycle("mis_b", 1'b0, 1'b1, 32'h0000_0303);
    cycle("mis_end", 1'b0, 1'b0, 32'h0);

    // PC wrap at the top of the address space
    cycle("wrap_redir", 1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle("wrap1", 1'b0, 1'b0, 32'h0);
    check("wrap.ifid_pc_const", IF_ID_PC, 32'hFFFF_FFFC);
    check("wrap.address_const", Address, 32'h0);
    cycle("wrap2", 1'b0, 1'b0, 32'h0);

    // Asynchronous reset while stalled at PC=0x40
    cycle("to40", 1'b0, 1'b1, 32'h0000_0040);
    cycle("stall40", 1'b1, 1'b0, 32'h0);
    Stall = 1'b1;
    check("stall40.address_const", Address, 32'h40);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    repeat (2) @(posedge clk);
    #1;
    check_all("async_hold");
    Stall = 1'b0;
    rst_n = 1'b1;
    cycle("reboot", 1'b0, 1'b0, 32'h0);
    check("reboot.valid_const", 32'(IF_ID_Valid), 32'd0);
    cycle("refetch", 1'b0, 1'b0, 32'h0);
    check("refetch.instr_const", IF_ID_Instruction, 32'hA000_0000);
    check("refetch.count_const", Fetch_Count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
